// File: rtl/bp_fe_fetch_ctrl_pkg.sv
// bp_fe_fetch_ctrl_pkg
//   Shared types and constants for the front-end fetch controller:
//   processor config enum, address/instruction widths, FSM state enum
//   and the in-flight tracker entry.
//   Optional feature macro used by the importing files:
//   BP_FE_FETCH_CTRL_MISALIGNED_EN
package bp_fe_fetch_ctrl_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int vaddr_width_gp = 39;
  localparam int instr_width_gp = 32;

  function automatic int vaddr_width_f(input bp_params_e cfg);
    unique case (cfg)
      e_bp_default_cfg: vaddr_width_f = vaddr_width_gp;
      default:          vaddr_width_f = vaddr_width_gp;
    endcase
  endfunction

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_run    = 2'd1,
    e_replay = 2'd2
  } bp_fe_fetch_ctrl_state_e;

  typedef struct packed {
    logic [vaddr_width_gp-1:0] pc;
    logic                      poison;
  } bp_fe_fetch_entry_s;

endpackage

// File: rtl/bp_fe_fetch_ctrl_if.sv
// bp_fe_fetch_ctrl_if
//   Bundles the I$ request/response handshake and the realigner-facing
//   fetch signals of bp_fe_fetch_ctrl.
//   master: the fetch controller; slave: I$ + realigner side.
//   Signals
//     icache_req_v_o / icache_req_pc_o / icache_req_ready_i : request
//     icache_resp_v_i / icache_resp_data_i                   : in-order response
//     fetch_v_o / fetch_store_v_o / fetch_pc_o / fetch_data_o: to realigner
//     fetch_instr_v_i / fetch_instr_yumi_i                   : realigner status
interface bp_fe_fetch_ctrl_if
  import bp_fe_fetch_ctrl_pkg::*;
#(
  parameter int vaddr_width_p = vaddr_width_gp,
  parameter int instr_width_p = instr_width_gp
);

  logic                     icache_req_v_o;
  logic [vaddr_width_p-1:0] icache_req_pc_o;
  logic                     icache_req_ready_i;
  logic                     icache_resp_v_i;
  logic [instr_width_p-1:0] icache_resp_data_i;
  logic                     fetch_v_o;
  logic                     fetch_store_v_o;
  logic [vaddr_width_p-1:0] fetch_pc_o;
  logic [instr_width_p-1:0] fetch_data_o;
  logic                     fetch_instr_v_i;
  logic                     fetch_instr_yumi_i;

  modport master (
    output icache_req_v_o, icache_req_pc_o,
    input  icache_req_ready_i,
    input  icache_resp_v_i, icache_resp_data_i,
    output fetch_v_o, fetch_store_v_o, fetch_pc_o, fetch_data_o,
    input  fetch_instr_v_i, fetch_instr_yumi_i
  );

  modport slave (
    input  icache_req_v_o, icache_req_pc_o,
    output icache_req_ready_i,
    output icache_resp_v_i, icache_resp_data_i,
    input  fetch_v_o, fetch_store_v_o, fetch_pc_o, fetch_data_o,
    output fetch_instr_v_i, fetch_instr_yumi_i
  );

endinterface

// File: rtl/bp_fe_fetch_tracker.sv
// bp_fe_fetch_tracker
//   In-order FIFO of in-flight I$ requests, outstanding_p entries deep.
//   Ports
//     clk_i, reset_n_i          : clock, async active-low reset
//     push_v_i, push_entry_i    : enqueue one request
//     pop_v_i, head_o           : dequeue oldest request / view it
//     poison_all_i              : mark every held entry (and one being
//                                 pushed this cycle) as stale
//     empty_o, full_o           : occupancy flags
module bp_fe_fetch_tracker
  import bp_fe_fetch_ctrl_pkg::*;
#(
  parameter int outstanding_p = 2
)(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_v_i,
  input  bp_fe_fetch_entry_s push_entry_i,
  input  logic               pop_v_i,
  output bp_fe_fetch_entry_s head_o,
  input  logic               poison_all_i,
  output logic               empty_o,
  output logic               full_o
);

  localparam int ptr_w_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(outstanding_p + 1);

  bp_fe_fetch_entry_s  mem_r [outstanding_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                push_ok, pop_ok;
  bp_fe_fetch_entry_s  push_entry;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_r == '0);
  assign full_o  = (cnt_r == cnt_w_lp'(outstanding_p));
  assign head_o  = mem_r[rptr_r];

  assign pop_ok  = pop_v_i & ~empty_o;
  // When full, a push only fits if the head leaves in the same cycle.
  assign push_ok = push_v_i & (~full_o | pop_ok);

  // A request issued in the same cycle as a poison event is already stale.
  always_comb begin
    push_entry        = push_entry_i;
    push_entry.poison = push_entry_i.poison | poison_all_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
      for (int i = 0; i < outstanding_p; i++) mem_r[i] <= '0;
    end else begin
      if (poison_all_i) begin
        for (int i = 0; i < outstanding_p; i++) mem_r[i].poison <= 1'b1;
      end
      if (push_ok) begin
        mem_r[wptr_r] <= push_entry;
        wptr_r        <= ptr_inc(wptr_r);
      end
      if (pop_ok) rptr_r <= ptr_inc(rptr_r);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_r <= cnt_r + cnt_w_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_w_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_fe_fetch_ctrl.sv
// bp_fe_fetch_ctrl
//   Issues I$ fetch requests from next_pc_r, tracks them in order, drops
//   stale responses after a redirect and feeds live ones to the realigner.
//   A realigned instruction the downstream queue refuses causes a replay
//   from the PC of the response that produced it.
//   Ports
//     clk_i, reset_n_i : clock, async active-low reset
//     redirect_v_i     : backend redirect
//     redirect_pc_i    : redirect target
//     bus (master)     : I$ request/response and realigner signals
//   Macro BP_FE_FETCH_CTRL_MISALIGNED_EN: when defined, halfword-aligned
//   (pc[1]=1) fetches are supported and fetch_store_v_o is driven; when
//   undefined every PC is forced word-aligned and fetch_store_v_o is 0.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   e_idle   | out of reset, nothing issued until a redirect
//   e_run    | issuing from next_pc_r while the tracker has room
//   e_replay | one bubble cycle after a replay, no request
module bp_fe_fetch_ctrl
  import bp_fe_fetch_ctrl_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter int         outstanding_p = 2,
  localparam int        vaddr_width_p = vaddr_width_f(bp_params_p)
)(
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  bp_fe_fetch_ctrl_if.master       bus
);

`ifdef BP_FE_FETCH_CTRL_MISALIGNED_EN
  localparam logic [vaddr_width_p-1:0] pc_mask_lp = '1;
`else
  localparam logic [vaddr_width_p-1:0] pc_mask_lp = ~vaddr_width_p'(2);
`endif

  bp_fe_fetch_ctrl_state_e  state_r;
  logic [vaddr_width_p-1:0] next_pc_r;
  logic [vaddr_width_p-1:0] pc_step;
  bp_fe_fetch_entry_s       head, push_entry;
  logic                     full, empty;
  logic                     req_v, req_fire, resp_v, fetch_v, fetch_store_v, replay;

  assign req_v    = (state_r == e_run) & ~full & ~redirect_v_i;
  assign req_fire = req_v & bus.icache_req_ready_i;

  assign resp_v   = bus.icache_resp_v_i & ~empty;
  assign fetch_v  = resp_v & ~head.poison & ~redirect_v_i;
  assign replay   = fetch_v & bus.fetch_instr_v_i & ~bus.fetch_instr_yumi_i;

`ifdef BP_FE_FETCH_CTRL_MISALIGNED_EN
  // A halfword-aligned fetch covers only up to the next word boundary.
  assign pc_step       = next_pc_r[1] ? vaddr_width_p'(2) : vaddr_width_p'(4);
  assign fetch_store_v = fetch_v & head.pc[1];
`else
  assign pc_step       = vaddr_width_p'(4);
  assign fetch_store_v = 1'b0;
`endif

  always_comb begin
    push_entry        = '0;
    push_entry.pc     = next_pc_r & pc_mask_lp;
    push_entry.poison = 1'b0;
  end

  bp_fe_fetch_tracker #(
    .outstanding_p(outstanding_p)
  ) tracker (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_v_i    (req_fire),
    .push_entry_i(push_entry),
    .pop_v_i     (bus.icache_resp_v_i),
    .head_o      (head),
    .poison_all_i(redirect_v_i | replay),
    .empty_o     (empty),
    .full_o      (full)
  );

  assign bus.icache_req_v_o  = req_v;
  assign bus.icache_req_pc_o = next_pc_r;
  assign bus.fetch_v_o       = fetch_v;
  assign bus.fetch_store_v_o = fetch_store_v;
  assign bus.fetch_pc_o      = resp_v ? head.pc : '0;
  assign bus.fetch_data_o    = resp_v ? bus.icache_resp_data_i : '0;

  // Redirect has priority; replay cannot coincide with it because
  // fetch_v already excludes the redirect cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= e_idle;
      next_pc_r <= '0;
    end else if (redirect_v_i) begin
      state_r   <= e_run;
      next_pc_r <= redirect_pc_i & pc_mask_lp;
    end else if (replay) begin
      state_r   <= e_replay;
      next_pc_r <= head.pc;
    end else begin
      unique case (state_r)
        e_idle:   state_r <= e_idle;
        e_run: begin
          state_r <= e_run;
          if (req_fire) next_pc_r <= next_pc_r + pc_step;
        end
        e_replay: state_r <= e_run;
        default:  state_r <= e_idle;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   bus.icache_resp_v_i |-> !empty)
    else $error("icache response with no request in flight");

endmodule
